// File: rtl/acc_rr_arbiter.sv
// acc_rr_arbiter
//   Shares one accelerator-bus slave between NumReq offloading requesters.
//   Q (request) channel: combinational round-robin mux with a grant lock, so a
//   request that is waiting on out_q_ready_i cannot be pre-empted or changed.
//   The request ID is extended with the requester index, which sits in the MSBs.
//   P (response) channel: a one-entry response register. Each response is routed
//   back to the requester named by the index field of its ID.
//
// Ports
//   clk_i, rst_i                       clock, synchronous active-high reset
//   in_q_*  [NumReq]                   requester-side request channels
//   in_p_*  [NumReq]                   requester-side responses (data/id/error broadcast)
//   out_q_*                            muxed request to the slave, ID = {index, id}
//   out_p_*                            slave response
//   drop_o                             pulse: accepted response with index >= NumReq was discarded

// Per-requester select logic: ready/valid steering for one requester port.
module acc_rr_lane #(
  parameter int IdxW    = 2,
  parameter int LaneIdx = 0
) (
  input  logic            rst_i,
  input  logic [IdxW-1:0] grant,
  input  logic            q_ready,
  input  logic [IdxW-1:0] rsp_idx,
  input  logic            rsp_full,
  input  logic            p_ready,
  output logic            in_q_ready,
  output logic            in_p_valid,
  output logic            drain
);
  logic q_sel, p_sel;

  assign q_sel      = (grant == IdxW'(LaneIdx));
  assign p_sel      = rsp_full && (rsp_idx == IdxW'(LaneIdx));
  assign in_q_ready = !rst_i && q_sel && q_ready;
  assign in_p_valid = !rst_i && p_sel;
  assign drain      = p_sel && p_ready;
endmodule

module acc_rr_arbiter #(
  parameter  int NumReq       = 4,
  parameter  int DataWidth    = 32,
  parameter  int AccAddrWidth = 2,
  parameter  int InIdWidth    = 2,
  localparam int IdxW         = $clog2(NumReq),
  localparam int ExtIdWidth   = InIdWidth + IdxW
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  // requester-side Q
  input  logic [NumReq-1:0][AccAddrWidth-1:0]  in_q_addr_i,
  input  logic [NumReq-1:0][31:0]              in_q_data_op_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     in_q_data_arga_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     in_q_data_argb_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     in_q_data_argc_i,
  input  logic [NumReq-1:0][InIdWidth-1:0]     in_q_id_i,
  input  logic [NumReq-1:0]                    in_q_valid_i,
  output logic [NumReq-1:0]                    in_q_ready_o,
  // requester-side P
  output logic [NumReq-1:0][DataWidth-1:0]     in_p_data_o,
  output logic [NumReq-1:0][ExtIdWidth-1:0]    in_p_id_o,
  output logic [NumReq-1:0]                    in_p_error_o,
  output logic [NumReq-1:0]                    in_p_valid_o,
  input  logic [NumReq-1:0]                    in_p_ready_i,
  // slave-side Q
  output logic [AccAddrWidth-1:0]              out_q_addr_o,
  output logic [31:0]                          out_q_data_op_o,
  output logic [DataWidth-1:0]                 out_q_data_arga_o,
  output logic [DataWidth-1:0]                 out_q_data_argb_o,
  output logic [DataWidth-1:0]                 out_q_data_argc_o,
  output logic [ExtIdWidth-1:0]                out_q_id_o,
  output logic                                 out_q_valid_o,
  input  logic                                 out_q_ready_i,
  // slave-side P
  input  logic [DataWidth-1:0]                 out_p_data_i,
  input  logic [ExtIdWidth-1:0]                out_p_id_i,
  input  logic                                 out_p_error_i,
  input  logic                                 out_p_valid_i,
  output logic                                 out_p_ready_o,
  output logic                                 drop_o
);

  typedef struct packed {
    logic [DataWidth-1:0]  data;
    logic [ExtIdWidth-1:0] id;
    logic                  error;
  } rsp_t;

  // ---------------------------------------------------------------- Q path
  logic [IdxW-1:0] rr_ptr, lock_idx, gnt_rr, grant, nxt_ptr;
  logic            lock, any_vld, q_valid, q_hs;

  // Round-robin search from rr_ptr, wrapping at NumReq (not at 2^IdxW).
  always_comb begin
    int j;
    j      = 0;
    gnt_rr = '0;
    any_vld = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NumReq) j = j - NumReq;
      if (!any_vld && in_q_valid_i[j]) begin
        any_vld = 1'b1;
        gnt_rr  = IdxW'(j);
      end
    end
  end

  assign grant   = lock ? lock_idx : gnt_rr;
  assign q_valid = lock ? in_q_valid_i[lock_idx] : any_vld;
  assign nxt_ptr = (int'(grant) == NumReq - 1) ? '0 : grant + IdxW'(1);

  assign out_q_valid_o     = !rst_i && q_valid;
  assign q_hs              = out_q_valid_o && out_q_ready_i;
  assign out_q_addr_o      = in_q_addr_i[grant];
  assign out_q_data_op_o   = in_q_data_op_i[grant];
  assign out_q_data_arga_o = in_q_data_arga_i[grant];
  assign out_q_data_argb_o = in_q_data_argb_i[grant];
  assign out_q_data_argc_o = in_q_data_argc_i[grant];
  assign out_q_id_o        = {grant, in_q_id_i[grant]};

  // Lock holds the grant while a request waits for ready; it is released only
  // by the handshake, so a waiting request cannot be swapped out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (q_hs) begin
      rr_ptr <= nxt_ptr;
      lock   <= 1'b0;
    end else if (out_q_valid_o) begin
      lock     <= 1'b1;
      lock_idx <= grant;
    end
  end

  // ---------------------------------------------------------------- P path
  rsp_t            rsp_q;
  logic            rsp_full, drain, cap, store;
  logic [IdxW-1:0] rsp_idx, cap_idx;
  logic [NumReq-1:0] lane_drain;

  assign rsp_idx = rsp_q.id[ExtIdWidth-1 -: IdxW];
  assign cap_idx = out_p_id_i[ExtIdWidth-1 -: IdxW];
  assign drain   = |lane_drain;

  // Accepting while draining keeps full throughput with a single entry.
  assign out_p_ready_o = !rst_i && (!rsp_full || drain);
  assign cap           = out_p_valid_i && out_p_ready_o;
  assign store         = cap && (int'(cap_idx) < NumReq);
  assign drop_o        = cap && !(int'(cap_idx) < NumReq);

  always_ff @(posedge clk_i) begin
    if (rst_i)      rsp_full <= 1'b0;
    else if (store) rsp_full <= 1'b1;
    else if (drain) rsp_full <= 1'b0;
  end

  // Payload needs no reset: it is only observed while rsp_full is set.
  always_ff @(posedge clk_i) begin
    if (store) rsp_q <= '{data: out_p_data_i, id: out_p_id_i, error: out_p_error_i};
  end

  // ---------------------------------------------------------------- lanes
  for (genvar g = 0; g < NumReq; g++) begin : g_lane
    acc_rr_lane #(.IdxW(IdxW), .LaneIdx(g)) u_lane (
      .rst_i      (rst_i),
      .grant      (grant),
      .q_ready    (out_q_ready_i),
      .rsp_idx    (rsp_idx),
      .rsp_full   (rsp_full),
      .p_ready    (in_p_ready_i[g]),
      .in_q_ready (in_q_ready_o[g]),
      .in_p_valid (in_p_valid_o[g]),
      .drain      (lane_drain[g])
    );
    assign in_p_data_o[g]  = rsp_q.data;
    assign in_p_id_o[g]    = rsp_q.id;
    assign in_p_error_o[g] = rsp_q.error;
  end

endmodule

// File: tb/tb_acc_rr_arbiter.sv
module tb_acc_rr_arbiter;
  localparam int NA = 4, NB = 3, DW = 32, AW = 2, IW = 2, EW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A (NumReq=4)
  logic [NA-1:0][AW-1:0] a_addr;
  logic [NA-1:0][31:0]   a_op, a_arga, a_argb, a_argc;
  logic [NA-1:0][IW-1:0] a_id;
  logic [NA-1:0]         a_qv, a_qr_o, a_rv, a_pr, a_rerr;
  logic [NA-1:0][DW-1:0] a_rdata;
  logic [NA-1:0][EW-1:0] a_rid;
  logic [AW-1:0] a_oaddr;
  logic [31:0]   a_oop, a_oa, a_ob, a_oc, a_pdata;
  logic [EW-1:0] a_oid, a_pid;
  logic a_oqv, a_qr, a_perr, a_pv, a_ordy, a_drop;

  acc_rr_arbiter #(.NumReq(NA), .DataWidth(DW), .AccAddrWidth(AW), .InIdWidth(IW)) u_a (
    .clk_i(clk), .rst_i(rst),
    .in_q_addr_i(a_addr), .in_q_data_op_i(a_op), .in_q_data_arga_i(a_arga),
    .in_q_data_argb_i(a_argb), .in_q_data_argc_i(a_argc), .in_q_id_i(a_id),
    .in_q_valid_i(a_qv), .in_q_ready_o(a_qr_o),
    .in_p_data_o(a_rdata), .in_p_id_o(a_rid), .in_p_error_o(a_rerr),
    .in_p_valid_o(a_rv), .in_p_ready_i(a_pr),
    .out_q_addr_o(a_oaddr), .out_q_data_op_o(a_oop), .out_q_data_arga_o(a_oa),
    .out_q_data_argb_o(a_ob), .out_q_data_argc_o(a_oc), .out_q_id_o(a_oid),
    .out_q_valid_o(a_oqv), .out_q_ready_i(a_qr),
    .out_p_data_i(a_pdata), .out_p_id_i(a_pid), .out_p_error_i(a_perr),
    .out_p_valid_i(a_pv), .out_p_ready_o(a_ordy), .drop_o(a_drop));

  // ---------------- DUT B (NumReq=3, non-power-of-2)
  logic [NB-1:0][AW-1:0] b_addr;
  logic [NB-1:0][31:0]   b_op, b_arga, b_argb, b_argc;
  logic [NB-1:0][IW-1:0] b_id;
  logic [NB-1:0]         b_qv, b_qr_o, b_rv, b_pr, b_rerr;
  logic [NB-1:0][DW-1:0] b_rdata;
  logic [NB-1:0][EW-1:0] b_rid;
  logic [AW-1:0] b_oaddr;
  logic [31:0]   b_oop, b_oa, b_ob, b_oc, b_pdata;
  logic [EW-1:0] b_oid, b_pid;
  logic b_oqv, b_qr, b_perr, b_pv, b_ordy, b_drop;

  acc_rr_arbiter #(.NumReq(NB), .DataWidth(DW), .AccAddrWidth(AW), .InIdWidth(IW)) u_b (
    .clk_i(clk), .rst_i(rst),
    .in_q_addr_i(b_addr), .in_q_data_op_i(b_op), .in_q_data_arga_i(b_arga),
    .in_q_data_argb_i(b_argb), .in_q_data_argc_i(b_argc), .in_q_id_i(b_id),
    .in_q_valid_i(b_qv), .in_q_ready_o(b_qr_o),
    .in_p_data_o(b_rdata), .in_p_id_o(b_rid), .in_p_error_o(b_rerr),
    .in_p_valid_o(b_rv), .in_p_ready_i(b_pr),
    .out_q_addr_o(b_oaddr), .out_q_data_op_o(b_oop), .out_q_data_arga_o(b_oa),
    .out_q_data_argb_o(b_ob), .out_q_data_argc_o(b_oc), .out_q_id_o(b_oid),
    .out_q_valid_o(b_oqv), .out_q_ready_i(b_qr),
    .out_p_data_i(b_pdata), .out_p_id_i(b_pid), .out_p_error_i(b_perr),
    .out_p_valid_i(b_pv), .out_p_ready_o(b_ordy), .drop_o(b_drop));

  // ---------------- reference model for DUT A (spec-level state)
  int          m_ptr, m_lidx;
  bit          m_lock, m_full;
  logic [31:0] m_data;
  logic [3:0]  m_id;
  logic        m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (m_lock) return m_lidx;
    for (int i = 0; i < NA; i++)
      if (a_qv[(m_ptr + i) % NA]) return (m_ptr + i) % NA;
    return -1;
  endfunction

  function automatic bit exp_qv();
    return m_lock ? a_qv[m_lidx] : (a_qv != '0);
  endfunction

  // Compare DUT A against the model, away from the active edge.
  task automatic sample();
    int g;
    logic [1:0] gi;
    logic [3:0] pidx;
    @(negedge clk);
    if (rst) begin
      chk("rst_q_valid", a_oqv, 0);
      chk("rst_q_ready", a_qr_o, 0);
      chk("rst_p_valid", a_rv, 0);
      chk("rst_p_ready", a_ordy, 0);
      chk("rst_drop", a_drop, 0);
    end else begin
      g  = exp_grant();
      gi = g[1:0];
      chk("q_valid", a_oqv, exp_qv());
      if (exp_qv()) begin
        chk("q_id", a_oid, {gi, a_id[g]});
        chk("q_op", a_oop, a_op[g]);
        chk("q_argb", a_ob, a_argb[g]);
        chk("q_ready", a_qr_o, a_qr ? (4'b1 << g) : 4'b0);
      end
      pidx = 4'b1 << m_id[3:2];
      chk("p_valid", a_rv, m_full ? pidx : 4'b0);
      if (m_full) begin
        for (int k = 0; k < NA; k++) begin
          chk("p_data", a_rdata[k], m_data);
          chk("p_id", a_rid[k], m_id);
          chk("p_err", a_rerr[k], m_err);
        end
      end
      chk("p_ready", a_ordy, !m_full || a_pr[m_id[3:2]]);
      chk("drop4", a_drop, 0);
    end
  endtask

  task automatic adv();
    int g;
    bit drn, prdy;
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_lock = 0; m_lidx = 0; m_full = 0;
    end else begin
      g = exp_grant();
      if (exp_qv() && a_qr) begin
        m_ptr = (g + 1) % NA; m_lock = 0;
      end else if (exp_qv()) begin
        m_lock = 1; m_lidx = g;
      end
      drn  = m_full && a_pr[m_id[3:2]];
      prdy = !m_full || drn;
      if (a_pv && prdy) begin
        m_full = 1; m_data = a_pdata; m_id = a_pid; m_err = a_perr;
      end else if (drn) m_full = 0;
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  initial begin
    m_ptr = 0; m_lidx = 0; m_lock = 0; m_full = 0;
    m_data = '0; m_id = '0; m_err = 0;
    // inputs active during reset so the output masking is exercised
    rst = 1;
    for (int i = 0; i < NA; i++) begin
      a_addr[i] = AW'(i); a_op[i] = 32'hA0 + i; a_arga[i] = 32'h100 + i;
      a_argb[i] = 32'h200 + i; a_argc[i] = 32'h300 + i; a_id[i] = IW'(3 - i);
    end
    for (int i = 0; i < NB; i++) begin
      b_addr[i] = AW'(i); b_op[i] = 32'hB0 + i; b_arga[i] = '0;
      b_argb[i] = '0; b_argc[i] = '0; b_id[i] = IW'(i);
    end
    a_qv = 4'hF; a_qr = 1; a_pv = 1; a_pid = 4'b0100; a_pdata = 32'hDEAD; a_perr = 0; a_pr = 4'hF;
    b_qv = 3'h7; b_qr = 1; b_pv = 1; b_pid = 4'b0000; b_pdata = 32'hBEEF; b_perr = 0; b_pr = 3'h7;
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("b_rst_q_valid", b_oqv, 0);
      chk("b_rst_q_ready", b_qr_o, 0);
      chk("b_rst_p_ready", b_ordy, 0);
      chk("b_rst_drop", b_drop, 0);
      adv();
    end
    rst = 0;
    a_pv = 0; b_qv = 0; b_pv = 0;

    // all four valid, ready high: strict rotation 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("t1_gnt", a_oid[3:2], k % 4);
      adv();
    end

    // lock: req1 waits three cycles, req0 arrives and must not preempt
    a_qv = 4'b0010; a_qr = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t2_gnt", a_oid[3:2], 1);
      chk("t2_op", a_oop, 32'hA1);
      adv();
      a_qv = 4'b0011;
    end
    a_qr = 1;
    sample();
    chk("t2_hs", a_qr_o, 4'b0010);
    adv();
    a_qv = 4'b0001;
    sample();
    chk("t2_next", a_oid[3:2], 0);
    chk("t2_next_rdy", a_qr_o, 4'b0001);
    adv();
    a_qv = 0; a_qr = 0;

    // response id 1001 routed to requester 2 and drained immediately
    a_pv = 1; a_pid = 4'b1001; a_pdata = 32'h1234; a_pr = 4'b0100;
    sample(); chk("t3_accept", a_ordy, 1); adv();
    a_pv = 0;
    sample();
    chk("t3_valid", a_rv, 4'b0100);
    chk("t3_id", a_rid[2], 4'b1001);
    adv();
    sample(); chk("t3_empty", a_rv, 0); adv();

    // back-to-back to requester 3 with two stalled cycles
    a_pr = 0; a_pv = 1; a_pid = 4'b1100; a_pdata = 32'h111;
    cyc();
    a_pid = 4'b1101; a_pdata = 32'h222;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("t4_stall", a_ordy, 0);
      chk("t4_hold", a_rdata[3], 32'h111);
      adv();
    end
    a_pr = 4'b1000;
    sample(); chk("t4_d1", a_rdata[3], 32'h111); chk("t4_rdy", a_ordy, 1); adv();
    a_pid = 4'b1110; a_pdata = 32'h333;
    sample(); chk("t4_d2", a_rdata[3], 32'h222); adv();
    a_pv = 0;
    sample(); chk("t4_d3", a_rdata[3], 32'h333); adv();
    sample(); chk("t4_empty", a_rv, 0); adv();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NA; i++) begin
        a_op[i] = $urandom; a_argb[i] = $urandom; a_id[i] = IW'($urandom_range(0, 3));
      end
      a_qv    = 4'($urandom_range(0, 15));
      a_qr    = ($urandom_range(0, 9) < 7);
      a_pv    = ($urandom_range(0, 9) < 6);
      a_pid   = 4'($urandom_range(0, 15));
      a_pdata = $urandom;
      a_perr  = 1'($urandom_range(0, 1));
      a_pr    = 4'($urandom_range(0, 15));
      cyc();
    end
    // flush: clear lock via handshakes and drain the register
    a_qv = 4'hF; a_qr = 1; a_pv = 0; a_pr = 4'hF;
    cyc(); cyc();

    // reset while locked and full
    a_qv = 4'b0100; a_qr = 0; a_pv = 1; a_pid = 4'b1000; a_pdata = 32'h55; a_pr = 0;
    cyc();
    a_pv = 0;
    sample();
    chk("t6_locked", a_oid[3:2], 2);
    chk("t6_full", a_rv, 4'b0100);
    adv();
    rst = 1; a_qv = 4'hF; a_qr = 1;
    cyc();
    rst = 0;
    sample();
    chk("t6_post_gnt", a_oid[3:2], 0);
    chk("t6_post_pv", a_rv, 0);
    adv();
    a_qv = 0; a_qr = 0;

    // NumReq=3: pointer wraps at 3
    b_qv = 3'h7; b_qr = 1;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("b_gnt", b_oid[3:2], k % 3);
      adv();
    end
    b_qv = 0; b_qr = 0;

    // NumReq=3: index 3 is out of range, response discarded
    b_pv = 1; b_pid = 4'b1100; b_pdata = 32'h77;
    sample();
    chk("b_drop", b_drop, 1);
    chk("b_drop_rdy", b_ordy, 1);
    chk("b_drop_pv", b_rv, 0);
    adv();
    b_pv = 0;
    sample(); chk("b_drop_pulse", b_drop, 0); chk("b_drop_notstored", b_rv, 0); adv();
    b_pv = 1; b_pid = 4'b1011; b_pdata = 32'h88;
    cyc();
    b_pv = 0;
    sample();
    chk("b_route", b_rv, 3'b100);
    chk("b_route_id", b_rid[2], 4'b1011);
    chk("b_route_data", b_rdata[2], 32'h88);
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
